// File: rtl/mmt_rd_sched.sv
// Read scheduler for the matrix triple-product engine: fetches op0/op1, runs
// the product phase, fetches op2, runs the reduction phase, then signals done.
module mmt_rd_sched #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 9,
    parameter int IDX_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [1:0]        job_size,
    input  logic [1:0]        job_mode,
    input  logic [IDX_W-1:0]  job_idx0,
    input  logic [IDX_W-1:0]  job_idx1,
    input  logic [IDX_W-1:0]  job_idx2,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              row_valid,
    output logic [1:0]        row_op,
    output logic [3:0]        row_num,
    output logic              row_tr,
    output logic              cal0_start,
    input  logic              cal0_done,
    output logic              cal1_start,
    input  logic              cal1_done,
    output logic              job_done,
    output logic              busy
);

    typedef enum logic [3:0] {
        IDLE, FETCH0, FETCH1, DRAIN0, WAIT0, FETCH2, DRAIN1, WAIT1, DONE
    } state_t;

    state_t             state;
    logic [1:0]         size_q, mode_q;
    logic [IDX_W-1:0]   idx0_q, idx1_q, idx2_q;
    logic [3:0]         r;
    logic [IDX_W-1:0]   cur_idx;
    logic [1:0]         iss_op;
    logic               iss_tr;
    logic [3:0]         last_row;
    logic [MEM_LAT-1:0] inflight;
    logic               drain_clear;

    logic [MEM_LAT:1]   vld_pipe;
    logic [6:0]         dat_pipe [1:MEM_LAT];

    function automatic logic [ADDR_W-1:0] row_addr(input logic [IDX_W-1:0] idx,
                                                   input logic [3:0] row);
        return ADDR_W'(idx) + (ADDR_W'(row) << 5);
    endfunction

    always_comb begin
        cur_idx = idx0_q;
        iss_op  = 2'd0;
        case (state)
            FETCH1:  begin cur_idx = idx1_q; iss_op = 2'd1; end
            FETCH2:  begin cur_idx = idx2_q; iss_op = 2'd2; end
            default: ;
        endcase
        iss_tr   = (mode_q == iss_op + 2'd1);
        last_row = 4'((5'd2 << size_q) - 5'd1);
        // Everything upstream of the output stage; once clear, the last row is on row_valid.
        inflight    = MEM_LAT'({vld_pipe, mem_rd_en});
        drain_clear = !mem_rd_en && (inflight == '0);
    end

    assign job_ready = (state == IDLE) && !rst;
    assign row_valid = vld_pipe[MEM_LAT];
    assign {row_op, row_num, row_tr} = dat_pipe[MEM_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            size_q     <= '0;
            mode_q     <= '0;
            idx0_q     <= '0;
            idx1_q     <= '0;
            idx2_q     <= '0;
            r          <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            cal0_start <= 1'b0;
            cal1_start <= 1'b0;
            job_done   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cal0_start <= 1'b0;
            cal1_start <= 1'b0;
            job_done   <= 1'b0;
            case (state)
                IDLE: if (job_valid) begin
                    size_q    <= job_size;
                    mode_q    <= job_mode;
                    idx0_q    <= job_idx0;
                    idx1_q    <= job_idx1;
                    idx2_q    <= job_idx2;
                    r         <= '0;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= row_addr(job_idx0, 4'd0);
                    busy      <= 1'b1;
                    state     <= FETCH0;
                end
                FETCH0, FETCH1, FETCH2: begin
                    if (r != last_row) begin
                        r        <= r + 4'd1;
                        mem_addr <= row_addr(cur_idx, r + 4'd1);
                    end else begin
                        r <= '0;
                        if (state == FETCH0) begin
                            mem_addr <= row_addr(idx1_q, 4'd0);
                            state    <= FETCH1;
                        end else begin
                            mem_rd_en <= 1'b0;
                            state     <= (state == FETCH1) ? DRAIN0 : DRAIN1;
                        end
                    end
                end
                DRAIN0: if (drain_clear) begin
                    cal0_start <= 1'b1;
                    state      <= WAIT0;
                end
                DRAIN1: if (drain_clear) begin
                    cal1_start <= 1'b1;
                    state      <= WAIT1;
                end
                // A done coincident with the start pulse belongs to a stale phase.
                WAIT0: if (cal0_done && !cal0_start) begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= row_addr(idx2_q, 4'd0);
                    state     <= FETCH2;
                end
                WAIT1: if (cal1_done && !cal1_start) begin
                    job_done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag pipe tracks SRAM latency so tags line up with returned data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 1; i <= MEM_LAT; i++) dat_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= mem_rd_en;
            dat_pipe[1] <= {iss_op, r, iss_tr};
            for (int i = 2; i <= MEM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mmt_rd_sched.sv
// Directed bench for mmt_rd_sched: dut_a runs with MEM_LAT=1, dut_b with MEM_LAT=3.
module tb_mmt_rd_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, job_valid_a, job_valid_b;
    logic [1:0] job_size, job_mode;
    logic [4:0] job_idx0, job_idx1, job_idx2;
    logic       cal0_done, cal1_done;

    logic       job_ready_a, mem_rd_en_a, row_valid_a, row_tr_a, cal0_start_a, cal1_start_a, job_done_a, busy_a;
    logic [8:0] mem_addr_a;
    logic [1:0] row_op_a;
    logic [3:0] row_num_a;
    logic       job_ready_b, mem_rd_en_b, row_valid_b, row_tr_b, cal0_start_b, cal1_start_b, job_done_b, busy_b;
    logic [8:0] mem_addr_b;
    logic [1:0] row_op_b;
    logic [3:0] row_num_b;

    mmt_rd_sched #(.MEM_LAT(1)) dut_a (
        .clk(clk), .rst(rst_a), .job_valid(job_valid_a), .job_ready(job_ready_a),
        .job_size(job_size), .job_mode(job_mode),
        .job_idx0(job_idx0), .job_idx1(job_idx1), .job_idx2(job_idx2),
        .mem_rd_en(mem_rd_en_a), .mem_addr(mem_addr_a), .row_valid(row_valid_a),
        .row_op(row_op_a), .row_num(row_num_a), .row_tr(row_tr_a),
        .cal0_start(cal0_start_a), .cal0_done(cal0_done),
        .cal1_start(cal1_start_a), .cal1_done(cal1_done),
        .job_done(job_done_a), .busy(busy_a)
    );

    mmt_rd_sched #(.MEM_LAT(3)) dut_b (
        .clk(clk), .rst(rst_b), .job_valid(job_valid_b), .job_ready(job_ready_b),
        .job_size(job_size), .job_mode(job_mode),
        .job_idx0(job_idx0), .job_idx1(job_idx1), .job_idx2(job_idx2),
        .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b), .row_valid(row_valid_b),
        .row_op(row_op_b), .row_num(row_num_b), .row_tr(row_tr_b),
        .cal0_start(cal0_start_b), .cal0_done(cal0_done),
        .cal1_start(cal1_start_b), .cal1_done(cal1_done),
        .job_done(job_done_b), .busy(busy_b)
    );

    logic [21:0] outs_a, outs_b;
    assign outs_a = {mem_rd_en_a, mem_addr_a, row_valid_a, row_op_a, row_num_a, row_tr_a,
                     cal0_start_a, cal1_start_a, job_done_a, busy_a};
    assign outs_b = {mem_rd_en_b, mem_addr_b, row_valid_b, row_op_b, row_num_b, row_tr_b,
                     cal0_start_b, cal1_start_b, job_done_b, busy_b};

    // Observation mux so the job driver can run against either instance.
    bit         sel;
    logic       o_rdy, o_rd, o_rv, o_tr, o_c0, o_c1, o_jd, o_busy;
    logic [8:0] o_addr;
    logic [1:0] o_op;
    logic [3:0] o_row;
    always_comb begin
        o_rdy  = sel ? job_ready_b  : job_ready_a;
        o_rd   = sel ? mem_rd_en_b  : mem_rd_en_a;
        o_addr = sel ? mem_addr_b   : mem_addr_a;
        o_rv   = sel ? row_valid_b  : row_valid_a;
        o_op   = sel ? row_op_b     : row_op_a;
        o_row  = sel ? row_num_b    : row_num_a;
        o_tr   = sel ? row_tr_b     : row_tr_a;
        o_c0   = sel ? cal0_start_b : cal0_start_a;
        o_c1   = sel ? cal1_start_b : cal1_start_a;
        o_jd   = sel ? job_done_b   : job_done_a;
        o_busy = sel ? busy_b       : busy_a;
    end

    int vectors = 0;
    int errors  = 0;

    int st_nrd, st_last0, st_rowerr, st_jd, st_c0, st_c1;
    int st_rv[3];
    int st_tr[3];
    bit st_to;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one job on the selected DUT, answering each start with a done one cycle later.
    task automatic run_job(input bit s, input logic [1:0] sz, input logic [1:0] md,
                           input logic [4:0] i0, input logic [4:0] i1, input logic [4:0] i2);
        int n, cyc;
        bit p0, p1;
        int nxt[3];
        n = 2 << sz;
        sel = s;
        st_nrd = 0; st_last0 = -1; st_rowerr = 0; st_jd = 0; st_c0 = 0; st_c1 = 0;
        st_rv = '{0, 0, 0}; st_tr = '{0, 0, 0}; nxt = '{0, 0, 0};
        p0 = 0; p1 = 0;
        cyc = 0;
        while (!o_rdy && cyc < 50) begin step(); cyc++; end
        job_size = sz; job_mode = md; job_idx0 = i0; job_idx1 = i1; job_idx2 = i2;
        if (s) job_valid_b = 1'b1; else job_valid_a = 1'b1;
        step();
        job_valid_a = 1'b0; job_valid_b = 1'b0;
        cyc = 1;
        st_to = 1;
        while (cyc < 3000) begin
            if (o_rd) begin
                if (st_nrd == n - 1) st_last0 = int'(o_addr);
                st_nrd++;
            end
            if (o_rv) begin
                if (o_op < 2'd3) begin
                    if (int'(o_row) == nxt[o_op]) nxt[o_op]++; else st_rowerr++;
                    st_rv[o_op]++;
                    if (o_tr) st_tr[o_op]++;
                end else st_rowerr++;
            end
            if (o_c0) st_c0 = cyc;
            if (o_c1) st_c1 = cyc;
            cal0_done = p0; cal1_done = p1;
            p0 = o_c0; p1 = o_c1;
            if (o_jd) begin st_jd++; st_to = 0; end
            step();
            cyc++;
            if (!st_to) break;
        end
        cal0_done = 1'b0; cal1_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1; rst_b = 1; job_valid_a = 0; job_valid_b = 0;
        job_size = 0; job_mode = 0; job_idx0 = 0; job_idx1 = 0; job_idx2 = 0;
        cal0_done = 0; cal1_done = 0; sel = 0;
        step(); step();
        vectors++;
        if ({outs_a, job_ready_a} !== 23'd0)
            begin errors++; $display("FAIL reset_a: got %h expected 0", {outs_a, job_ready_a}); end
        vectors++;
        if ({outs_b, job_ready_b} !== 23'd0)
            begin errors++; $display("FAIL reset_b: got %h expected 0", {outs_b, job_ready_b}); end
        rst_a = 0; rst_b = 0;
        #1;
        vectors++;
        if ({job_ready_a, job_ready_b, busy_a, busy_b} !== 4'b1100)
            begin errors++; $display("FAIL reset_release: got %b expected 1100", {job_ready_a, job_ready_b, busy_a, busy_b}); end
    endtask

    task automatic test_basic();
        int e_rd[1:16]   = '{1,1,1,1,0,0,0,0,0,1,1,0,0,0,0,0};
        int e_addr[1:16] = '{3,35,7,39,39,39,39,39,39,31,63,63,63,63,63,63};
        int e_rv[1:16]   = '{0,1,1,1,1,0,0,0,0,0,1,1,0,0,0,0};
        int e_op[1:16]   = '{0,0,0,1,1,0,0,0,0,0,2,2,0,0,0,0};
        int e_row[1:16]  = '{0,0,1,0,1,0,0,0,0,0,0,1,0,0,0,0};
        logic [22:0] exp_v, obs_v;
        sel = 0;
        job_size = 0; job_mode = 0; job_idx0 = 3; job_idx1 = 7; job_idx2 = 31;
        job_valid_a = 1;
        step();
        job_valid_a = 0;
        for (int k = 1; k <= 16; k++) begin
            cal0_done = (k == 9);
            cal1_done = (k == 14);
            exp_v = {e_rd[k] != 0, 9'(e_addr[k]), e_rv[k] != 0, 2'(e_op[k]), 4'(e_row[k]), 1'b0,
                     k == 6, k == 13, k == 15, k < 16, k == 16};
            obs_v = {mem_rd_en_a, mem_addr_a, row_valid_a,
                     row_valid_a ? row_op_a : 2'd0, row_valid_a ? row_num_a : 4'd0,
                     row_valid_a ? row_tr_a : 1'b0,
                     cal0_start_a, cal1_start_a, job_done_a, busy_a, job_ready_a};
            vectors++;
            if (obs_v !== exp_v)
                begin errors++; $display("FAIL basic_cycle_t+%0d: got %h expected %h", k, obs_v, exp_v); end
            step();
        end
        cal0_done = 0; cal1_done = 0;
    endtask

    task automatic test_size3();
        run_job(0, 2'd3, 2'd0, 5'd31, 5'd0, 5'd5);
        vectors++;
        if (st_to || st_jd != 1)
            begin errors++; $display("FAIL size3_done: got jd=%0d timeout=%0d expected jd=1", st_jd, st_to); end
        vectors++;
        if (st_nrd != 48)
            begin errors++; $display("FAIL size3_reads: got %0d expected 48", st_nrd); end
        vectors++;
        if (st_last0 != 511)
            begin errors++; $display("FAIL size3_last_op0_addr: got %0d expected 511", st_last0); end
        vectors++;
        if (st_rv[0] != 16 || st_rv[1] != 16 || st_rv[2] != 16 || st_rowerr != 0)
            begin errors++; $display("FAIL size3_rows: got %0d/%0d/%0d rowerr=%0d expected 16/16/16 rowerr=0",
                                     st_rv[0], st_rv[1], st_rv[2], st_rowerr); end
    endtask

    task automatic test_modes();
        for (int m = 0; m < 4; m++) begin
            run_job(0, 2'd0, 2'(m), 5'd1, 5'd2, 5'd3);
            vectors++;
            if (st_tr[0] != ((m == 1) ? 2 : 0) || st_tr[1] != ((m == 2) ? 2 : 0) ||
                st_tr[2] != ((m == 3) ? 2 : 0) || st_jd != 1)
                begin errors++; $display("FAIL mode%0d_tr: got %0d/%0d/%0d jd=%0d", m, st_tr[0], st_tr[1], st_tr[2], st_jd); end
            vectors++;
            if (st_rv[0] != 2 || st_rv[1] != 2 || st_rv[2] != 2 || st_rowerr != 0)
                begin errors++; $display("FAIL mode%0d_rows: got %0d/%0d/%0d rowerr=%0d expected 2/2/2 rowerr=0",
                                         m, st_rv[0], st_rv[1], st_rv[2], st_rowerr); end
        end
    endtask

    task automatic test_done_timing();
        int cyc;
        sel = 0;
        job_size = 0; job_mode = 0; job_idx0 = 4; job_idx1 = 8; job_idx2 = 12;
        job_valid_a = 1;
        step();
        job_valid_a = 0;
        step(); step();
        cal1_done = 1;            // stray done during FETCH1
        step(); step();
        cal1_done = 0;
        cyc = 0;
        while (!cal0_start_a && cyc < 20) begin step(); cyc++; end
        vectors++;
        if (cal0_start_a !== 1'b1)
            begin errors++; $display("FAIL dt_cal0_start: got %b expected 1", cal0_start_a); end
        cal0_done = 1;
        step();
        vectors++;
        if ({mem_rd_en_a, busy_a} !== 2'b01)
            begin errors++; $display("FAIL dt_done_in_start_cycle: got rd=%b busy=%b expected rd=0 busy=1", mem_rd_en_a, busy_a); end
        step();
        vectors++;
        if (mem_rd_en_a !== 1'b1 || mem_addr_a !== 9'd12)
            begin errors++; $display("FAIL dt_fetch2_start: got rd=%b addr=%0d expected rd=1 addr=12", mem_rd_en_a, mem_addr_a); end
        cal0_done = 0;
        cyc = 0;
        while (!cal1_start_a && cyc < 20) begin step(); cyc++; end
        step();
        cal1_done = 1;
        step();
        cal1_done = 0;
        vectors++;
        if (job_done_a !== 1'b1)
            begin errors++; $display("FAIL dt_job_done: got %b expected 1", job_done_a); end
        step();
    endtask

    task automatic test_reset_mid();
        int bad;
        sel = 1;
        job_size = 1; job_mode = 0; job_idx0 = 1; job_idx1 = 2; job_idx2 = 3;
        job_valid_b = 1;
        step();
        job_valid_b = 0;
        repeat (5) step();        // cycle t+6: FETCH1, row 1
        vectors++;
        if (mem_rd_en_b !== 1'b1 || mem_addr_b !== 9'd34)
            begin errors++; $display("FAIL rm_in_fetch1: got rd=%b addr=%0d expected rd=1 addr=34", mem_rd_en_b, mem_addr_b); end
        rst_b = 1;
        step();
        vectors++;
        if ({outs_b, job_ready_b} !== 23'd0)
            begin errors++; $display("FAIL rm_outputs_cleared: got %h expected 0", {outs_b, job_ready_b}); end
        rst_b = 0;
        #1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (row_valid_b || mem_rd_en_b || busy_b || job_done_b || !job_ready_b) bad++;
            step();
        end
        vectors++;
        if (bad != 0)
            begin errors++; $display("FAIL rm_no_stale_rows: got %0d bad cycles expected 0", bad); end
        run_job(1, 2'd0, 2'd3, 5'd10, 5'd20, 5'd30);
        vectors++;
        if (st_to || st_jd != 1 || st_rv[0] != 2 || st_rv[1] != 2 || st_rv[2] != 2 || st_rowerr != 0)
            begin errors++; $display("FAIL rm_new_job: got jd=%0d rows=%0d/%0d/%0d rowerr=%0d", st_jd, st_rv[0], st_rv[1], st_rv[2], st_rowerr); end
        vectors++;
        if (st_tr[0] != 0 || st_tr[1] != 0 || st_tr[2] != 2)
            begin errors++; $display("FAIL rm_new_job_tr: got %0d/%0d/%0d expected 0/0/2", st_tr[0], st_tr[1], st_tr[2]); end
        vectors++;
        if (st_c0 != 8 || st_c1 != 15)
            begin errors++; $display("FAIL lat3_start_timing: got c0=t+%0d c1=t+%0d expected t+8 t+15", st_c0, st_c1); end
    endtask

    task automatic test_back_to_back();
        int acc, ovl, nrd, ntr, jd, cyc;
        bit p0, p1;
        sel = 0;
        acc = 0; ovl = 0; nrd = 0; ntr = 0; jd = 0; cyc = 0; p0 = 0; p1 = 0;
        job_size = 0; job_mode = 2; job_idx0 = 6; job_idx1 = 9; job_idx2 = 12;
        job_valid_a = 1;
        while (jd < 3 && cyc < 300) begin
            if (job_ready_a) acc++;
            if (job_ready_a && (busy_a || mem_rd_en_a)) ovl++;
            if (mem_rd_en_a) nrd++;
            if (row_valid_a && row_tr_a) begin
                ntr++;
                if (row_op_a != 2'd1) ovl++;
            end
            cal0_done = p0; cal1_done = p1;
            p0 = cal0_start_a; p1 = cal1_start_a;
            if (job_done_a) jd++;
            if (jd == 3) job_valid_a = 0;
            step();
            cyc++;
        end
        job_valid_a = 0; cal0_done = 0; cal1_done = 0;
        vectors++;
        if (jd != 3)
            begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", jd); end
        vectors++;
        if (acc != 3)
            begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", acc); end
        vectors++;
        if (nrd != 18 || ntr != 6 || ovl != 0)
            begin errors++; $display("FAIL b2b_reads: got rd=%0d tr=%0d ovl=%0d expected rd=18 tr=6 ovl=0", nrd, ntr, ovl); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_size3();
        test_modes();
        test_done_timing();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mmt_rd_sched.md
Name: mmt_rd_sched

Overview:
- Read scheduler and sequencer for the matrix triple-product engine.
- Accepts one job: size, mode and three matrix indices. Issues row reads to the 16-bank matrix SRAM (one row per read, address = idx + 32*row).
- Tags each returned row with operand number, row number and transpose flag, then hands the datapath its two compute phases through start/done handshakes.
- Sits between the job input FIFO and the SRAM/datapath; the datapath only consumes rows and reports done.

Parameters:
- MEM_LAT, 1, SRAM read latency in cycles (legal 1..3); row_valid trails mem_rd_en by exactly MEM_LAT.
- ADDR_W, 9, SRAM address width.
- IDX_W, 5, matrix index width (32 matrices).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- job_valid  in  1  job request present.
- job_ready  out  1  scheduler can accept a job.
- job_size  in  2  N = 2 << job_size (2, 4, 8, 16).
- job_mode  in  2  0: none transposed; 1: op0 transposed; 2: op1 transposed; 3: op2 transposed.
- job_idx0, job_idx1, job_idx2  in  IDX_W each  matrix indices for op0, op1, op2.
- mem_rd_en  out  1  SRAM read strobe.
- mem_addr  out  ADDR_W  SRAM row address.
- row_valid  out  1  SRAM data for the tagged row is valid this cycle.
- row_op  out  2  operand 0/1/2 of the current row.
- row_num  out  4  row index 0..N-1.
- row_tr  out  1  row is to be written transposed.
- cal0_start  out  1  one-cycle pulse: op0 and op1 loaded, start product phase.
- cal0_done  in  1  datapath finished phase 0.
- cal1_start  out  1  one-cycle pulse: op2 loaded, start reduction phase.
- cal1_done  in  1  datapath finished phase 1.
- job_done  out  1  one-cycle pulse at job completion.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst high at an edge): state IDLE. Read pipe cleared. mem_rd_en, mem_addr, row_valid, row_op, row_num, row_tr, cal0_start, cal1_start, job_done, busy all 0. job_ready = (state==IDLE) && !rst.
- Reset mid-job: abandons the job with no done pulse. Reads already issued produce no row_valid.
- States: IDLE, FETCH0, FETCH1, DRAIN0, WAIT0, FETCH2, DRAIN1, WAIT1, DONE.
- IDLE: accept on job_valid && job_ready. Register size, mode and the indices, then go to FETCH0. job_valid in any other state is ignored.
- FETCHk (k = 0, 1, 2):
  - mem_rd_en=1 every cycle; row counter r goes 0..N-1; mem_addr = idx_k + 32*r, computed as a 9-bit zero-extended sum with no wrap (max 31+480 = 511).
  - FETCH0 goes to FETCH1 after issuing r=N-1, with no bubble.
  - FETCH1 goes to DRAIN0 after issuing r=N-1.
  - FETCH2 goes to DRAIN1 after issuing r=N-1.
- Read pipe: {rd_en, op, r, tr} delayed MEM_LAT stages drive row_valid/row_op/row_num/row_tr. row_tr = (mode==op+1).
- DRAINk: mem_rd_en=0. Wait until the pipe is empty (last row_valid seen). Next cycle, pulse cal0_start (from DRAIN0) or cal1_start (from DRAIN1) and enter WAIT0 or WAIT1.
- WAIT0/WAIT1: hold until the matching done input is sampled high.
  - The done input is sampled only from the cycle after the start pulse; done high in the start cycle is ignored.
  - WAIT0 goes to FETCH2. WAIT1 goes to DONE.
- DONE: job_done=1 for one cycle, then IDLE. job_ready returns to 1 the cycle after DONE.
- Unexpected cal0_done/cal1_done in other states: ignored.
- mem_addr holds its last value when mem_rd_en=0.
- Throughput: fetches take 3N cycles, plus 2*(MEM_LAT+1) drain cycles, plus datapath phase times, plus 2 (accept/DONE).

Test Plan:
- MEM_LAT=1. Job size=0, mode=0, idx=(3,7,31), accepted at edge t.
  - mem_addr 3, 35, 7, 39 in cycles t+1..t+4.
  - row_valid t+2..t+5 with (op,row) = (0,0), (0,1), (1,0), (1,1) and row_tr=0.
  - cal0_start at t+6.
  - cal0_done at t+9 gives addr 31, 63 at t+10, t+11, then cal1_start at t+13.
  - cal1_done at t+14 gives job_done at t+15 and job_ready at t+16.
- size=3, idx0=31: last op0 address 511; exactly 16 reads per operand; row_num 0..15.
- Modes 1, 2, 3: row_tr high only on op0, op1 or op2 rows respectively; mode 0 never asserts it.
- Done timing: cal0_done held high during the cal0_start cycle is ignored. Assert it 1 cycle later and FETCH2 begins next edge. A stray cal1_done during FETCH1 has no effect.
- rst pulsed during FETCH1 (MEM_LAT=3): next cycle all outputs 0. No row_valid from reads in flight. job_ready=1 after rst drops. A new job runs normally.
- job_valid held high continuously with back-to-back jobs: each accepted only in IDLE, one job_done per job, no overlapping fetches.
